io_uart: RTL and testbench

//  Memory-mapped 8N1 UART responder on the processor io bus (io_write_en/io_read_en/io_address/io_write_data
//  -> io_read_data). Drives the board uart_tx pin and receives on uart_rx. Software polls a status register,

---
 rtl/io_uart_pkg.sv | 31 +++
 rtl/io_uart_rx_fifo.sv | 64 ++++++
 rtl/io_uart.sv | 274 +++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart block: io bus data type, register
// offsets relative to BASE_ADDRESS, STATUS bit positions and the TX/RX
// state encodings.
package io_uart_pkg;

  typedef logic [31:0] scalar_t;

  localparam scalar_t STATUS_OFFSET  = 32'h0;
  localparam scalar_t RX_DATA_OFFSET = 32'h4;
  localparam scalar_t TX_DATA_OFFSET = 32'h8;

  localparam int STATUS_RX_AVAIL  = 0;
  localparam int STATUS_TX_READY  = 1;
  localparam int STATUS_OVERRUN   = 2;
  localparam int STATUS_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/io_uart_rx_fifo.sv
// Synchronous receive FIFO for io_uart.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_push, i_data  write a byte (ignored when full unless popping the same cycle)
//   i_pop           remove the head byte (ignored when empty)
//   o_data          current head byte (combinational)
//   o_full/o_empty  occupancy flags
//   o_count         number of stored bytes
module io_uart_rx_fifo
  import io_uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // an empty FIFO cannot pop, so push+pop on empty is a plain push.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART responder on the processor io bus.
// Registers (byte addresses relative to BASE_ADDRESS):
//   +0 STATUS  (R) [0] rx_avail [1] tx_ready [2] overrun [3] frame_err; read clears [3:2]
//   +4 RX_DATA (R) [7:0] FIFO head, popped by the read; 0 when empty
//   +8 TX_DATA (W) [7:0] byte to transmit, dropped while a frame is in flight
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   io_write_en, io_read_en        single-cycle access strobes
//   io_address, io_write_data      io byte address and write data
//   io_read_data                   registered read data, 0 when not addressed
//   uart_tx                        serial output, idle high
//   uart_rx                        serial input, asynchronous to clk
// Build option: define IO_UART_LOOPBACK_EN to feed the receiver from the
// internal TX line instead of the uart_rx pin (board self-test).
module io_uart
  import io_uart_pkg::*;
#(
  parameter scalar_t BASE_ADDRESS = 32'h18,
  parameter int      BAUD_DIVIDE  = 434,
  parameter int      FIFO_DEPTH   = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    io_write_en,
  input  logic    io_read_en,
  input  scalar_t io_address,
  input  scalar_t io_write_data,
  output scalar_t io_read_data,
  output logic    uart_tx,
  input  logic    uart_rx
);

  localparam int               CNT_W      = $clog2(BAUD_DIVIDE);
  localparam int               FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BAUD_DIVIDE / 2 - 1);

  // ---------------- address decode ----------------
  logic w_sel_status, w_sel_rx, w_sel_tx;
  logic w_rd_status, w_rd_rx, w_tx_wr;
  logic w_unused_wdata;

  assign w_sel_status   = (io_address == BASE_ADDRESS + STATUS_OFFSET);
  assign w_sel_rx       = (io_address == BASE_ADDRESS + RX_DATA_OFFSET);
  assign w_sel_tx       = (io_address == BASE_ADDRESS + TX_DATA_OFFSET);
  assign w_rd_status    = io_read_en && w_sel_status;
  assign w_rd_rx        = io_read_en && w_sel_rx;
  assign w_unused_wdata = ^io_write_data[31:8];

  // ---------------- transmitter ----------------
  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_tx_line, w_tx_line_nxt;
  logic             w_tx_ready;

  assign w_tx_ready = (r_tx_state == TX_IDLE);
  assign w_tx_wr    = io_write_en && w_sel_tx && w_tx_ready;
  assign uart_tx    = r_tx_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  // The line level is registered from the next state so the pin never
  // glitches while the state/counter flops change together.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_wr) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = io_write_data[7:0];
          w_tx_cnt_nxt   = '0;
          w_tx_line_nxt  = 1'b0;
        end
      end
      TX_START: begin
        w_tx_line_nxt = 1'b0;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_line_nxt  = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        w_tx_line_nxt = r_tx_shift[0];
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_line_nxt  = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 1'b1;
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_tx_line_nxt  = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_cnt_nxt   = '0;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic             w_rx_in;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             w_rx_push, w_frame_set;

`ifdef IO_UART_LOOPBACK_EN
  assign w_rx_in = r_tx_line;
`else
  assign w_rx_in = uart_rx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= w_rx_in;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Only a falling edge starts a frame, so after a bad stop bit the
  // receiver ignores the still-low line until it has gone high again.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_frame_set    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_push      = r_rx_sync;
          w_frame_set    = !r_rx_sync;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]            w_fifo_data;
  logic                  w_fifo_full, w_fifo_empty;
  logic [FIFO_CNT_W-1:0] w_fifo_count;
  logic                  w_pop, w_overrun_set;

  assign w_pop         = w_rd_rx && !w_fifo_empty;
  assign w_overrun_set = w_rx_push && w_fifo_full && !w_pop;

  io_uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // ---------------- status and read data ----------------
  logic    r_overrun, r_frame_err;
  scalar_t w_status;
  scalar_t r_read_data;

  always_comb begin
    w_status                   = '0;
    w_status[STATUS_RX_AVAIL]  = (w_fifo_count != '0);
    w_status[STATUS_TX_READY]  = w_tx_ready;
    w_status[STATUS_OVERRUN]   = r_overrun;
    w_status[STATUS_FRAME_ERR] = r_frame_err;
  end

  assign io_read_data = r_read_data;

  // A new error in the same cycle as a STATUS read wins over the clear,
  // so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_overrun   <= w_overrun_set | (r_overrun & ~w_rd_status);
      r_frame_err <= w_frame_set | (r_frame_err & ~w_rd_status);
      if (io_read_en) begin
        if (w_rd_status)   r_read_data <= w_status;
        else if (w_rd_rx)  r_read_data <= {24'h0, (w_fifo_empty ? 8'h00 : w_fifo_data)};
        else               r_read_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_uart.sv
module tb_io_uart;

  localparam int          BD        = 8;
  localparam logic [31:0] A_STATUS  = 32'h18;
  localparam logic [31:0] A_RX      = 32'h1C;
  localparam logic [31:0] A_TX      = 32'h20;

  logic        clk;
  logic        reset;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx;

  int n_checks = 0;
  int n_errors = 0;

  io_uart #(
    .BASE_ADDRESS (32'h18),
    .BAUD_DIVIDE  (BD),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model of the receive side: a bounded queue plus two flags.
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic       m_fe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end just after a falling clock edge.
  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    io_write_en   = 1'b1;
    io_address    = a;
    io_write_data = d;
    @(negedge clk);
    io_write_en   = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    io_read_en = 1'b1;
    io_address = a;
    @(negedge clk);
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    io_read(a, d);
    check(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected serial level t clocks after the write was accepted.
  function automatic logic exp_line(input logic [7:0] b, input int t);
    if (t < BD) return 1'b0;
    if (t < 9 * BD) return b[(t - BD) / BD];
    return 1'b1;
  endfunction

  task automatic tx_test(input logic [7:0] b, input bit try_second, input string name);
    int bad;
    bad = 0;
    io_write_en   = 1'b1;
    io_address    = A_TX;
    io_write_data = {24'h0, b};
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (t == 0) io_write_en = 1'b0;
      if (uart_tx !== exp_line(b, t)) bad++;
      if (try_second && t == 20) begin
        io_write_en   = 1'b1;
        io_address    = A_TX;
        io_write_data = 32'hFF;
      end
      if (try_second && t == 21) io_write_en = 1'b0;
      if (t == 30) begin
        io_read_en = 1'b1;
        io_address = A_STATUS;
      end
      if (t == 31) begin
        io_read_en = 1'b0;
        check({name, "_busy"}, io_read_data & 32'h2, 32'h0);
      end
    end
    check({name, "_wave"}, bad, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BD);
    end
    uart_rx = good_stop;
    idle(BD);
    uart_rx = 1'b1;
    idle(4);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rb;
    logic [31:0] exp;
    int          r;

    reset         = 1'b1;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    uart_rx       = 1'b1;
    m_ovr         = 1'b0;
    m_fe          = 1'b0;
    idle(3);
    check("reset_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_rdata", io_read_data, 32'h0);
    reset = 1'b0;
    idle(2);

    vecs[0] = '{wr: 1'b0, addr: A_STATUS,  data: 32'h0,  exp: 32'h2};
    vecs[1] = '{wr: 1'b0, addr: 32'h24,    data: 32'h0,  exp: 32'h0};
    vecs[2] = '{wr: 1'b0, addr: A_RX,      data: 32'h0,  exp: 32'h0};
    vecs[3] = '{wr: 1'b1, addr: A_STATUS,  data: 32'h41, exp: 32'h0};
    vecs[4] = '{wr: 1'b1, addr: A_RX,      data: 32'h41, exp: 32'h0};
    vecs[5] = '{wr: 1'b1, addr: 32'h24,    data: 32'h41, exp: 32'h0};
    vecs[6] = '{wr: 1'b0, addr: A_STATUS,  data: 32'h0,  exp: 32'h2};
    vecs[7] = '{wr: 1'b0, addr: A_TX,      data: 32'h0,  exp: 32'h0};
    vecs[8] = '{wr: 1'b0, addr: 32'h19,    data: 32'h0,  exp: 32'h0};
    vecs[9] = '{wr: 1'b0, addr: A_STATUS,  data: 32'h0,  exp: 32'h2};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        io_write(vecs[i].addr, vecs[i].data);
      end else begin
        io_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    idle(3);
    check("rdata_hold", io_read_data, 32'h2);
    check("tx_idle_after_table", {31'h0, uart_tx}, 32'h1);

`ifdef IO_UART_LOOPBACK_EN
    io_write(A_TX, 32'h3C);
    idle(100);
    read_check("lb_status", A_STATUS, 32'h3);
    read_check("lb_data", A_RX, 32'h3C);
    read_check("lb_status2", A_STATUS, 32'h2);
`else
    tx_test(8'h55, 1'b1, "tx55");
    read_check("tx55_ready", A_STATUS, 32'h2);
    rb = 8'($urandom);
    tx_test(rb, 1'b0, "txrand");
    read_check("txrand_ready", A_STATUS, 32'h2);

    send_frame(8'hA3, 1'b1);
    read_check("rxA3_status", A_STATUS, 32'h3);
    read_check("rxA3_data", A_RX, 32'hA3);
    read_check("rxA3_status2", A_STATUS, 32'h2);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    read_check("ovr_status", A_STATUS, 32'h7);
    for (int i = 1; i <= 4; i++) read_check($sformatf("ovr_data%0d", i), A_RX, 32'(i));
    read_check("ovr_empty", A_RX, 32'h0);
    read_check("ovr_cleared", A_STATUS, 32'h2);

    send_frame(8'h5A, 1'b0);
    read_check("fe_status", A_STATUS, 32'hA);
    read_check("fe_cleared", A_STATUS, 32'h2);
    read_check("fe_nopush", A_RX, 32'h0);

    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(40);
    read_check("glitch_status", A_STATUS, 32'h2);
    read_check("glitch_nopush", A_RX, 32'h0);

    io_write(A_TX, 32'h00);
    idle(20);
    check("tx_mid_frame", {31'h0, uart_tx}, 32'h0);
    #2 reset = 1'b1;
    #1 check("tx_async_reset", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    read_check("post_reset_status", A_STATUS, 32'h2);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          send_frame(rb, 1'b0);
          m_fe = 1'b1;
        end else begin
          send_frame(rb, 1'b1);
          if (m_q.size() < 4) m_q.push_back(rb);
          else m_ovr = 1'b1;
        end
      end else if (r < 8) begin
        exp = (m_q.size() != 0) ? {24'h0, m_q.pop_front()} : 32'h0;
        read_check($sformatf("rand%0d_data", n), A_RX, exp);
      end else begin
        exp = {28'h0, m_fe, m_ovr, 1'b1, (m_q.size() != 0)};
        read_check($sformatf("rand%0d_status", n), A_STATUS, exp);
        m_fe  = 1'b0;
        m_ovr = 1'b0;
      end
    end
    while (m_q.size() != 0) begin
      exp = {24'h0, m_q.pop_front()};
      read_check("drain_data", A_RX, exp);
    end
    exp = {28'h0, m_fe, m_ovr, 2'b10};
    read_check("final_status", A_STATUS, exp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
